// File: rtl/adbg_pkg.sv
// Shared types and helpers for the cross-trigger halt controller.
// Holds the halt FSM state encoding and the core-index width helper.
// Imported by the controller, its priority encoder and the bench.
package adbg_pkg;

    // Halt episode states: IDLE -> HALTING -> HALTED -> RESUMING -> IDLE
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HALTING  = 2'd1,
        HALTED   = 2'd2,
        RESUMING = 2'd3
    } halt_state_e;

    // Width of an index into n items; never narrower than one bit
    function automatic int adbg_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Larger of two integers, used to size the shared episode counter
    function automatic int adbg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adbg_halt_ctrl_if.sv
// Trigger event port: one pending event (core, ext, overflow) plus ack.
// Latency: event fields are registered in the controller.
// Backpressure: valid holds until ack; later triggers only set overflow.
interface adbg_halt_ctrl_if #(
    parameter int CW = 2
);
    logic          trig_valid_o;
    logic [CW-1:0] trig_core_o;
    logic          trig_ext_o;
    logic          trig_ovf_o;
    logic          trig_ack_i;

    // Controller side: produces the event, consumes the ack
    modport master (
        output trig_valid_o,
        output trig_core_o,
        output trig_ext_o,
        output trig_ovf_o,
        input  trig_ack_i
    );

    // Debugger side: observes the event, returns the ack
    modport slave (
        input  trig_valid_o,
        input  trig_core_o,
        input  trig_ext_o,
        input  trig_ovf_o,
        output trig_ack_i
    );
endinterface

// File: rtl/adbg_prio_enc.sv
// Lowest-index priority encoder: index of the lowest set request bit.
// Latency: purely combinational.
// Backpressure: none; any_o flags that idx_o is meaningful.
module adbg_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Scan from the top down so the lowest set bit is the last writer
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adbg_halt_ctrl.sv
// Cross-trigger halt controller: per-core breakpoints, debugger stall
// requests and global halt/resume drive registered per-core stall lines.
// Latency: bp edge N -> stall/event after N+2; halt_all N -> after N+1.
// Backpressure: one pending event held until ack; extra triggers set ovf.
// Build option: define ADBG_CROSS_TRIGGER_EN for group cross-triggering;
// without it only halt_all_i starts an episode and breakpoints stay local.
module adbg_halt_ctrl
    import adbg_pkg::*;
#(
    parameter int NB_CORES     = 4,
    parameter int HALT_SETTLE  = 2,
    parameter int RESUME_GUARD = 4
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    input  logic [NB_CORES-1:0] dbg_stall_req_i,
    input  logic [NB_CORES-1:0] cpu_bp_i,
    input  logic [NB_CORES-1:0] group_mask_i,
    input  logic                group_en_i,
    input  logic                halt_all_i,
    input  logic                resume_all_i,
    output logic [NB_CORES-1:0] cpu_stall_o,
    output logic                halted_o,
    adbg_halt_ctrl_if.master    evt
);

    localparam int CW    = adbg_idx_w(NB_CORES);
    localparam int CNT_W = adbg_idx_w(adbg_max(HALT_SETTLE, RESUME_GUARD));
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(HALT_SETTLE - 1);
    localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(RESUME_GUARD - 1);

    // Breakpoint edge detection
    logic [NB_CORES-1:0] cpu_bp_q;
    logic [NB_CORES-1:0] bp_rise_q;
    logic [NB_CORES-1:0] bp_latch_q, bp_latch_d;

    // Episode FSM
    halt_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grp_stall_q, grp_stall_d;
    logic                grp_all_q, grp_all_d;
    logic                latch_clr;

    // Accepted trigger, staged one cycle ahead of the event registers
    logic                acc_q, acc_d;
    logic                acc_ext_q, acc_ext_d;
    logic [CW-1:0]       acc_core_q, acc_core_d;

    // Event port and stall outputs
    logic                trig_valid_q;
    logic [CW-1:0]       trig_core_q;
    logic                trig_ext_q;
    logic                trig_ovf_q;
    logic [NB_CORES-1:0] stall_q;
    logic                halted_q;

    // Group-qualified breakpoint rises and the mask the group stall uses
    logic [NB_CORES-1:0] grp_rise;
    logic [NB_CORES-1:0] mask_eff;
    logic [CW-1:0]       rise_idx;
    logic                rise_any;

`ifdef ADBG_CROSS_TRIGGER_EN
    assign grp_rise = group_en_i ? (bp_rise_q & group_mask_i) : '0;
    assign mask_eff = group_mask_i;
`else
    // Group controls have no function here; halt_all_i is the only trigger
    logic unused_cfg;
    assign unused_cfg = ^{group_en_i, group_mask_i};
    assign grp_rise   = '0;
    assign mask_eff   = '0;
`endif

    adbg_prio_enc #(
        .N (NB_CORES),
        .W (CW)
    ) u_prio_enc (
        .req_i (grp_rise),
        .idx_o (rise_idx),
        .any_o (rise_any)
    );

    // Register the raw breakpoint level and its rising edge
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cpu_bp_q  <= '0;
            bp_rise_q <= '0;
        end else begin
            cpu_bp_q  <= cpu_bp_i;
            bp_rise_q <= cpu_bp_i & ~cpu_bp_q;
        end
    end

    // Breakpoint latches: set on a rise outside the guard window, cleared on resume
    always_comb begin
        bp_latch_d = bp_latch_q;
        if (latch_clr) begin
            bp_latch_d = '0;
        end else if (state_q != RESUMING) begin
            bp_latch_d = bp_latch_q | bp_rise_q;
        end
    end

    // Next-state and episode control for the halt FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grp_stall_d = grp_stall_q;
        grp_all_d   = grp_all_q;
        latch_clr   = 1'b0;
        acc_d       = 1'b0;
        acc_ext_d   = acc_ext_q;
        acc_core_d  = acc_core_q;
        case (state_q)
            IDLE: begin
                // halt_all_i wins over a simultaneous resume or breakpoint
                if (halt_all_i || rise_any) begin
                    state_d     = HALTING;
                    cnt_d       = SETTLE_LD;
                    grp_stall_d = 1'b1;
                    grp_all_d   = halt_all_i;
                    acc_d       = 1'b1;
                    acc_ext_d   = halt_all_i;
                    acc_core_d  = halt_all_i ? '0 : rise_idx;
                end
            end
            HALTING: begin
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                if (resume_all_i) begin
                    state_d     = RESUMING;
                    cnt_d       = GUARD_LD;
                    grp_stall_d = 1'b0;
                    grp_all_d   = 1'b0;
                    latch_clr   = 1'b1;
                end
            end
            RESUMING: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counter, group stall and staged-trigger registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grp_stall_q <= 1'b0;
            grp_all_q   <= 1'b0;
            bp_latch_q  <= '0;
            acc_q       <= 1'b0;
            acc_ext_q   <= 1'b0;
            acc_core_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grp_stall_q <= grp_stall_d;
            grp_all_q   <= grp_all_d;
            bp_latch_q  <= bp_latch_d;
            acc_q       <= acc_d;
            acc_ext_q   <= acc_ext_d;
            acc_core_q  <= acc_core_d;
        end
    end

    // Per-core stall from the previous-edge latch and group state; halted flag
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stall_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            stall_q  <= dbg_stall_req_i | bp_latch_q
                      | ({NB_CORES{grp_stall_q}} & ({NB_CORES{grp_all_q}} | mask_eff));
            halted_q <= (state_q == HALTED);
        end
    end

    // Event slot: first trigger is kept, later ones before ack only flag overflow
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            trig_valid_q <= 1'b0;
            trig_core_q  <= '0;
            trig_ext_q   <= 1'b0;
            trig_ovf_q   <= 1'b0;
        end else if (acc_q) begin
            if (trig_valid_q && !evt.trig_ack_i) begin
                trig_ovf_q <= 1'b1;
            end else begin
                trig_valid_q <= 1'b1;
                trig_core_q  <= acc_core_q;
                trig_ext_q   <= acc_ext_q;
                trig_ovf_q   <= 1'b0;
            end
        end else if (trig_valid_q && evt.trig_ack_i) begin
            trig_valid_q <= 1'b0;
            trig_ovf_q   <= 1'b0;
        end
    end

    assign cpu_stall_o      = stall_q;
    assign halted_o         = halted_q;
    assign evt.trig_valid_o = trig_valid_q;
    assign evt.trig_core_o  = trig_core_q;
    assign evt.trig_ext_o   = trig_ext_q;
    assign evt.trig_ovf_o   = trig_ovf_q;

endmodule
